// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-stage types: ALU/write-back/branch encodings, the EX/MEM
// bundle and the operand-forwarding priority rule.
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU   = 3'b000,
    WB_MEM   = 3'b001,
    WB_PC4   = 3'b010,
    WB_IMM   = 3'b011,
    WB_AUIPC = 3'b100
  } wb_sel_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_f3_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  wb_sel;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    word_t       ex_result;
    word_t       write_data;
    word_t       pc_plus4;
  } exmem_t;

  // M stage wins over W; x0 is never forwarded.
  function automatic word_t fwd_operand(input logic [4:0] rs, input word_t rf_val,
                                        input logic m_we, input logic [4:0] m_rd,
                                        input word_t m_val, input logic w_we,
                                        input logic [4:0] w_rd, input word_t w_val);
    if (m_we && (m_rd != 5'd0) && (m_rd == rs)) return m_val;
    if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return w_val;
    return rf_val;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// E-stage bundle in, write-back forwarding source in, redirect and EX/MEM
// register contents out.
interface ex_stage_if;
  import rv32i_pkg::*;

  logic        RegWriteE, MemReadE, MemWriteE, ALUSrcE, JumpE, BranchE, MuxjalrE;
  logic [3:0]  ALUOpE;
  logic [2:0]  WriteBackE, funct3E;
  word_t       RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;

  word_t       ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW;

  logic        PCSrcE;
  word_t       PCTargetE;

  logic        RegWriteM, MemReadM, MemWriteM;
  logic [2:0]  WriteBackM, funct3M;
  logic [4:0]  RdM;
  word_t       ExResultM, WriteDataM, PCPlus4M;

  modport master (
    output RegWriteE, MemReadE, MemWriteE, ALUSrcE, JumpE, BranchE, MuxjalrE,
           ALUOpE, WriteBackE, funct3E, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
           RdE, Rs1E, Rs2E, ResultW, RdW, RegWriteW,
    input  PCSrcE, PCTargetE, RegWriteM, MemReadM, MemWriteM, WriteBackM,
           funct3M, RdM, ExResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, MemReadE, MemWriteE, ALUSrcE, JumpE, BranchE, MuxjalrE,
           ALUOpE, WriteBackE, funct3E, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
           RdE, Rs1E, Rs2E, ResultW, RdW, RegWriteW,
    output PCSrcE, PCTargetE, RegWriteM, MemReadM, MemWriteM, WriteBackM,
           funct3M, RdM, ExResultM, WriteDataM, PCPlus4M
  );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU; unused opcodes (1010-1111) yield zero.
module alu
  import rv32i_pkg::*;
(
  input  word_t      src_a_i,
  input  word_t      src_b_i,
  input  logic [3:0] alu_op_i,
  output word_t      result_o
);

  logic [4:0] shamt;
  assign shamt = src_b_i[4:0];

  always_comb begin
    // NOTE: default assignment first keeps this block purely combinational (no latch).
    result_o = '0;
    case (alu_op_i)
      ALU_ADD:  result_o = src_a_i + src_b_i;
      ALU_SUB:  result_o = src_a_i - src_b_i;
      ALU_SLL:  result_o = src_a_i << shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, src_a_i < src_b_i};
      ALU_XOR:  result_o = src_a_i ^ src_b_i;
      ALU_SRL:  result_o = src_a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(src_a_i) >>> shamt);
      ALU_OR:   result_o = src_a_i | src_b_i;
      ALU_AND:  result_o = src_a_i & src_b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: M/W forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register.
module ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input logic       clk,
  input logic       reset,
  input logic       StallM,
  ex_stage_if.slave bus
);

  logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_res, ex_result_e;
  logic [XLEN-1:0] pc_imm, jalr_sum;
  logic            taken;
  exmem_t          m_q, m_d;

  // Forwarding sources come from this stage's own EX/MEM register.
  assign fwd_a = FWD_EN ? fwd_operand(bus.Rs1E, bus.RD1E, m_q.reg_write, m_q.rd,
                                      m_q.ex_result, bus.RegWriteW, bus.RdW, bus.ResultW)
                        : bus.RD1E;
  assign fwd_b = FWD_EN ? fwd_operand(bus.Rs2E, bus.RD2E, m_q.reg_write, m_q.rd,
                                      m_q.ex_result, bus.RegWriteW, bus.RdW, bus.ResultW)
                        : bus.RD2E;

  assign src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;

  alu u_alu (
    .src_a_i  (fwd_a),
    .src_b_i  (src_b),
    .alu_op_i (bus.ALUOpE),
    .result_o (alu_res)
  );

  // Branches compare the forwarded register operands, never the immediate.
  always_comb begin
    taken = 1'b0;
    case (bus.funct3E)
      BR_EQ:   taken = (fwd_a == fwd_b);
      BR_NE:   taken = (fwd_a != fwd_b);
      BR_LT:   taken = ($signed(fwd_a) <  $signed(fwd_b));
      BR_GE:   taken = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  taken = (fwd_a <  fwd_b);
      BR_GEU:  taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign pc_imm        = bus.PCE + bus.ImmExtE;
  assign jalr_sum      = fwd_a + bus.ImmExtE;
  assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & taken);
  assign bus.PCTargetE = bus.MuxjalrE ? {jalr_sum[XLEN-1:1], 1'b0} : pc_imm;

  always_comb begin
    ex_result_e = alu_res;
    case (bus.WriteBackE)
      WB_PC4:   ex_result_e = bus.PCPlus4E;
      WB_IMM:   ex_result_e = bus.ImmExtE;
      WB_AUIPC: ex_result_e = pc_imm;
      default:  ex_result_e = alu_res;
    endcase
  end

  always_comb begin
    m_d            = '0;
    m_d.reg_write  = bus.RegWriteE;
    m_d.mem_read   = bus.MemReadE;
    m_d.mem_write  = bus.MemWriteE;
    m_d.wb_sel     = bus.WriteBackE;
    m_d.funct3     = bus.funct3E;
    m_d.rd         = bus.RdE;
    m_d.ex_result  = ex_result_e;
    m_d.write_data = fwd_b;
    m_d.pc_plus4   = bus.PCPlus4E;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for state; synchronous reset is checked before the stall hold.
    if (reset)        m_q <= '0;
    else if (!StallM) m_q <= m_d;
  end

  assign bus.RegWriteM  = m_q.reg_write;
  assign bus.MemReadM   = m_q.mem_read;
  assign bus.MemWriteM  = m_q.mem_write;
  assign bus.WriteBackM = m_q.wb_sel;
  assign bus.funct3M    = m_q.funct3;
  assign bus.RdM        = m_q.rd;
  assign bus.ExResultM  = m_q.ex_result;
  assign bus.WriteDataM = m_q.write_data;
  assign bus.PCPlus4M   = m_q.pc_plus4;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_ex_stage;

  logic clk = 1'b0;
  logic reset, StallM;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .StallM (StallM),
    .bus    (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected EX/MEM contents, tracked independently of the DUT.
  logic        e_rw = 0, e_mr = 0, e_mw = 0;
  logic [2:0]  e_wb = 0, e_f3 = 0;
  logic [4:0]  e_rd = 0;
  logic [31:0] e_res = 0, e_wd = 0, e_pc4 = 0;

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf,
                                          input logic mw, input logic [4:0] mrd,
                                          input logic [31:0] mv, input logic ww,
                                          input logic [4:0] wrd, input logic [31:0] wv);
    if (rs != 0 && mw && mrd == rs) return mv;
    if (rs != 0 && ww && wrd == rs) return wv;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return 32'($signed(a) >>> b[4:0]);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] f3);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return !($signed(a) < $signed(b));
      3'd6: return a < b;
      3'd7: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  logic [31:0] m_fwd_a, m_fwd_b, m_alu, m_res, m_target;
  logic        m_pcsrc;

  always_comb begin
    m_fwd_a  = ref_fwd(bus.Rs1E, bus.RD1E, e_rw, e_rd, e_res, bus.RegWriteW, bus.RdW, bus.ResultW);
    m_fwd_b  = ref_fwd(bus.Rs2E, bus.RD2E, e_rw, e_rd, e_res, bus.RegWriteW, bus.RdW, bus.ResultW);
    m_alu    = ref_alu(m_fwd_a, bus.ALUSrcE ? bus.ImmExtE : m_fwd_b, bus.ALUOpE);
    m_res    = (bus.WriteBackE == 3'd2) ? bus.PCPlus4E :
               (bus.WriteBackE == 3'd3) ? bus.ImmExtE :
               (bus.WriteBackE == 3'd4) ? bus.PCE + bus.ImmExtE : m_alu;
    m_pcsrc  = bus.JumpE | (bus.BranchE & ref_taken(m_fwd_a, m_fwd_b, bus.funct3E));
    m_target = bus.MuxjalrE ? ((m_fwd_a + bus.ImmExtE) & 32'hFFFF_FFFE)
                            : bus.PCE + bus.ImmExtE;
  end

  always @(posedge clk) begin
    if (reset) begin
      e_rw <= 0; e_mr <= 0; e_mw <= 0; e_wb <= 0; e_f3 <= 0; e_rd <= 0;
      e_res <= 0; e_wd <= 0; e_pc4 <= 0;
    end else if (!StallM) begin
      e_rw <= bus.RegWriteE; e_mr <= bus.MemReadE; e_mw <= bus.MemWriteE;
      e_wb <= bus.WriteBackE; e_f3 <= bus.funct3E; e_rd <= bus.RdE;
      e_res <= m_res; e_wd <= m_fwd_b; e_pc4 <= bus.PCPlus4E;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("PCSrcE",     32'(bus.PCSrcE),     32'(m_pcsrc));
      check("PCTargetE",  bus.PCTargetE,       m_target);
      check("RegWriteM",  32'(bus.RegWriteM),  32'(e_rw));
      check("MemReadM",   32'(bus.MemReadM),   32'(e_mr));
      check("MemWriteM",  32'(bus.MemWriteM),  32'(e_mw));
      check("WriteBackM", 32'(bus.WriteBackM), 32'(e_wb));
      check("funct3M",    32'(bus.funct3M),    32'(e_f3));
      check("RdM",        32'(bus.RdM),        32'(e_rd));
      check("ExResultM",  bus.ExResultM,       e_res);
      check("WriteDataM", bus.WriteDataM,      e_wd);
      check("PCPlus4M",   bus.PCPlus4M,        e_pc4);
    end
  end

  task automatic idle();
    bus.RegWriteE = 0; bus.MemReadE = 0; bus.MemWriteE = 0; bus.ALUSrcE = 0;
    bus.JumpE = 0; bus.BranchE = 0; bus.MuxjalrE = 0; bus.ALUOpE = 0;
    bus.WriteBackE = 0; bus.funct3E = 0; bus.RD1E = 0; bus.RD2E = 0; bus.PCE = 0;
    bus.ImmExtE = 0; bus.PCPlus4E = 0; bus.RdE = 0; bus.Rs1E = 0; bus.Rs2E = 0;
    bus.ResultW = 0; bus.RdW = 0; bus.RegWriteW = 0; StallM = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, "_ExResultM"},  bus.ExResultM, 32'd0);
    check({tag, "_WriteDataM"}, bus.WriteDataM, 32'd0);
    check({tag, "_PCPlus4M"},   bus.PCPlus4M, 32'd0);
    check({tag, "_RdM"},        32'(bus.RdM), 32'd0);
    check({tag, "_RegWriteM"},  32'(bus.RegWriteM), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle();
    tick();
    tick();
    reset = 0;
    started = 1;
    check_m_zero("reset");

    // SUB 5-7
    bus.RD1E = 5; bus.RD2E = 7; bus.Rs1E = 10; bus.Rs2E = 11; bus.ALUOpE = 4'b0001;
    tick();
    check("sub_ExResultM", bus.ExResultM, 32'hFFFF_FFFE);

    // SRA by immediate
    idle();
    bus.RD1E = 32'h8000_0000; bus.ImmExtE = 4; bus.ALUSrcE = 1; bus.ALUOpE = 4'b0111;
    tick();
    check("sra_ExResultM", bus.ExResultM, 32'hF800_0000);

    // Load M with x3 = 0x11
    idle();
    bus.RegWriteE = 1; bus.RdE = 3; bus.RD1E = 32'h11;
    tick();
    check("fwd_setup_RdM", 32'(bus.RdM), 32'd3);

    // M and W both target x3: M wins (0x11, bit0 cleared by JALR mask)
    idle();
    bus.Rs1E = 3; bus.RD1E = 32'h56; bus.RdW = 3; bus.ResultW = 32'h22; bus.RegWriteW = 1;
    bus.MuxjalrE = 1; bus.ALUSrcE = 1; bus.RegWriteE = 1; bus.RdE = 0;
    settle();
    check("fwd_m_prio", bus.PCTargetE, 32'h10);
    tick();
    settle();
    check("fwd_w_when_rdm0", bus.PCTargetE, 32'h22);
    bus.Rs1E = 0; bus.RdW = 0;
    settle();
    check("fwd_x0_raw", bus.PCTargetE, 32'h56);
    tick();

    // BLT / BLTU on 0xFFFFFFFF vs 1
    idle();
    bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 1; bus.BranchE = 1; bus.funct3E = 3'b100;
    bus.PCE = 32'h100; bus.ImmExtE = 32'h20;
    settle();
    check("blt_PCSrcE", 32'(bus.PCSrcE), 32'd1);
    check("br_PCTargetE", bus.PCTargetE, 32'h120);
    bus.funct3E = 3'b110;
    settle();
    check("bltu_PCSrcE", 32'(bus.PCSrcE), 32'd0);
    tick();

    // JALR
    idle();
    bus.MuxjalrE = 1; bus.JumpE = 1; bus.RD1E = 32'h1003; bus.ImmExtE = 2;
    bus.WriteBackE = 3'b010; bus.PCPlus4E = 32'h104; bus.RegWriteE = 1; bus.RdE = 1;
    settle();
    check("jalr_PCTargetE", bus.PCTargetE, 32'h1004);
    check("jalr_PCSrcE", 32'(bus.PCSrcE), 32'd1);
    tick();
    check("jalr_ExResultM", bus.ExResultM, 32'h104);

    // Stall holds for three cycles while E inputs change
    idle();
    StallM = 1; bus.RD1E = 32'hDEAD; bus.RdE = 7; bus.RegWriteE = 0; bus.PCPlus4E = 32'h999;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ExResultM", bus.ExResultM, 32'h104);
      check("stall_RdM", 32'(bus.RdM), 32'd1);
      check("stall_RegWriteM", 32'(bus.RegWriteM), 32'd1);
    end

    // Reset beats stall
    reset = 1;
    tick();
    check_m_zero("rst_stall");
    reset = 0;

    // AUIPC
    idle();
    bus.PCE = 32'h200; bus.ImmExtE = 32'h1000; bus.WriteBackE = 3'b100;
    tick();
    check("auipc_ExResultM", bus.ExResultM, 32'h1200);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus.RegWriteE  = 1'($urandom_range(0, 1));
      bus.MemReadE   = 1'($urandom_range(0, 1));
      bus.MemWriteE  = 1'($urandom_range(0, 1));
      bus.ALUSrcE    = 1'($urandom_range(0, 1));
      bus.JumpE      = ($urandom_range(0, 7) == 0);
      bus.BranchE    = 1'($urandom_range(0, 1));
      bus.MuxjalrE   = 1'($urandom_range(0, 1));
      bus.ALUOpE     = 4'($urandom_range(0, 15));
      bus.WriteBackE = 3'($urandom_range(0, 7));
      bus.funct3E    = 3'($urandom_range(0, 7));
      bus.RD1E       = $urandom;
      bus.RD2E       = ($urandom_range(0, 3) == 0) ? bus.RD1E : $urandom;
      bus.PCE        = $urandom;
      bus.ImmExtE    = $urandom;
      bus.PCPlus4E   = $urandom;
      bus.RdE        = 5'($urandom_range(0, 3));
      bus.Rs1E       = 5'($urandom_range(0, 3));
      bus.Rs2E       = 5'($urandom_range(0, 3));
      bus.ResultW    = $urandom;
      bus.RdW        = 5'($urandom_range(0, 3));
      bus.RegWriteW  = 1'($urandom_range(0, 1));
      StallM         = ($urandom_range(0, 4) == 0);
      reset          = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 0;
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I 5-stage pipeline.
- Consumes the E-stage control/data bundle from the ID/EX register.
- Performs operand forwarding, ALU operation, branch/jump resolution and target generation.
- Owns the EX/MEM pipeline register that feeds the memory stage.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
FWD_EN, 1, 1 = internal M/W forwarding enabled; 0 = raw RD1E/RD2E used.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
StallM  in  1  hold EX/MEM register (memory wait)
RegWriteE, MemReadE, MemWriteE, ALUSrcE, JumpE, BranchE, MuxjalrE  in  1 each  E-stage controls
ALUOpE  in  4  ALU operation
WriteBackE, funct3E  in  3 each  result select; funct3
RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  32 each  operands/PC
RdE, Rs1E, Rs2E  in  5 each  register indices
ResultW  in  32  write-back value
RdW  in  5  write-back destination
RegWriteW  in  1  write-back enable
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  32  redirect address (combinational)
RegWriteM, MemReadM, MemWriteM  out  1 each  registered controls
WriteBackM, funct3M  out  3 each  registered
RdM  out  5  registered
ExResultM, WriteDataM, PCPlus4M  out  32 each  registered

Behaviour:
- Reset (reset=1 at posedge clk): every registered M output is cleared to 0. Combinational outputs follow E inputs. Reset has priority over StallM.
- Forwarding of operand A (from Rs1E); operand B (from Rs2E) is identical:
  - Select ExResultM if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Otherwise select ResultW if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Otherwise select RD1E.
  - M has priority over W. Index x0 is never forwarded.
  - Load-use hazards are stalled upstream; this block does not detect them.
- ALU: SrcA = fwdA; SrcB = ALUSrcE ? ImmExtE : fwdB.
  - ALUOpE encoding: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
  - 1010–1111 produce 0.
  - Shift amount = SrcB[4:0]. Arithmetic wraps modulo 2^32.
- WriteBackE encoding:
  - 000 ALU
  - 001 MEM (ExResult = ALU address)
  - 010 PC+4
  - 011 ImmExtE (LUI)
  - 100 PCE+ImmExtE (AUIPC)
  - 101–111 ALU
  - ExResultE is the selected value; it is registered to ExResultM.
- Branch compare uses fwdA vs fwdB (never SrcB).
  - funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010/011: not taken.
- PCSrcE = JumpE | (BranchE & taken).
- PCTargetE = MuxjalrE ? ((fwdA + ImmExtE) & ~1) : (PCE + ImmExtE).
- PCTargetE is valid every cycle regardless of PCSrcE. Flushing IF/ID and ID/EX is the hazard unit's job.
- EX/MEM register, one cycle latency:
  - StallM=1: all M outputs hold.
  - Otherwise load E values; WriteDataM = fwdB.
  - Bubbles arriving with RegWriteE=MemWriteE=0 propagate unchanged.
- Simultaneous StallM and a W write matching Rs: forwarding still uses the current ResultW. Holding the E bundle is the upstream stall's responsibility.

Decomposition:
- Package rv32i_pkg holds:
  - ALUOp constants
  - WriteBack select constants
  - Branch funct3 constants
  - XLEN
- Sub-module alu (combinational: SrcA, SrcB, ALUOp -> result) is natural.
- Forwarding, branch compare and the EX/MEM register stay in ex_stage.

Test Plan:
- ADD/SUB: RD1E=5, RD2E=7, ALUOpE=0001 -> ExResultM=0xFFFFFFFE one cycle later. SRA with RD1E=0x80000000, ImmExtE=4, ALUSrcE=1 -> 0xF8000000.
- Forwarding priority: RdM=3/RegWriteM=1/ExResultM=0x11 and RdW=3/ResultW=0x22, Rs1E=3 -> operand A is 0x11. Same with RdM=0 -> 0x22. Rs1E=0 with RdW=0 -> RD1E used.
- Branch: BLT with fwdA=0xFFFFFFFF, fwdB=1 -> PCSrcE=1. BLTU with the same operands -> PCSrcE=0. PCE=0x100, ImmExtE=0x20 -> PCTargetE=0x120.
- JALR: MuxjalrE=1, JumpE=1, fwdA=0x1003, ImmExtE=2 -> PCTargetE=0x1004, PCSrcE=1. WriteBackE=010, PCPlus4E=0x104 -> ExResultM=0x104.
- Stall/reset: StallM=1 for 3 cycles -> M outputs unchanged. reset=1 concurrent with StallM=1 -> all M outputs 0 at that edge. AUIPC PCE=0x200, ImmExtE=0x1000 -> ExResultM=0x1200.
